// File: rtl/vip_pkg.sv
// Shared definitions for the VIP morphology frame controller: mode codes,
// FSM encoding, default border width and bit-selection helpers.
package vip_pkg;

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_ERODE  = 2'd1;
    localparam logic [1:0] MODE_DILATE = 2'd2;

    localparam int DEF_BORDER = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // Reserved mode 3 falls through to the raw bit.
    function automatic logic sel_bit(input logic [1:0] mode, input logic raw, input logic ero,
                                     input logic dil);
        case (mode)
            MODE_ERODE:  return ero;
            MODE_DILATE: return dil;
            default:     return raw;
        endcase
    endfunction

    function automatic logic is_morph(input logic [1:0] mode);
        return (mode == MODE_ERODE) || (mode == MODE_DILATE);
    endfunction

endpackage

// File: rtl/vip_sync_edge.sv
// Registers one sync line and flags its rising/falling edges on the input cycle.
module vip_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic sig_q,
    output logic rise,
    output logic fall
);

    logic armed;

    // A rise is only trusted once the line has been seen low since reset;
    // otherwise a reset in the middle of a pulse would fake an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            sig_q <= sig;
            armed <= armed | ~sig;
        end
    end

    assign rise = sig & ~sig_q & armed;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/vip_morph_frame_ctrl.sv
// Frame controller for the 9x9 morphology stage: frame-aligned mode commit,
// position tracking, bit selection and border blanking.
// Frame counter and geometry check are built only with MORPH_STATS_EN.
module vip_morph_frame_ctrl
    import vip_pkg::*;
#(
    parameter int IMG_HSIZE = 640,
    parameter int IMG_VSIZE = 480,
    parameter int BORDER    = DEF_BORDER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_valid,
    input  logic [1:0]  cfg_mode,
    output logic        cfg_ready,
    input  logic        in_frame_vsync,
    input  logic        in_frame_href,
    input  logic        in_frame_clken,
    input  logic        in_raw_bit,
    input  logic        in_ero_bit,
    input  logic        in_dil_bit,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_Bit,
    output logic [1:0]  active_mode,
    output logic [15:0] frame_cnt,
    output logic        geom_err
);

    localparam int CW = $clog2(IMG_HSIZE + 1);
    localparam int RW = $clog2(IMG_VSIZE + 1);
    localparam logic [CW-1:0] H_MAX = CW'(IMG_HSIZE);
    localparam logic [CW-1:0] H_LO  = CW'(BORDER);
    localparam logic [CW-1:0] H_HI  = CW'(IMG_HSIZE - BORDER);
    localparam logic [RW-1:0] V_MAX = RW'(IMG_VSIZE);
    localparam logic [RW-1:0] V_LO  = RW'(BORDER);
    localparam logic [RW-1:0] V_HI  = RW'(IMG_VSIZE - BORDER);

    logic          vs_rise, vs_fall, hs_rise, hs_fall;
    state_t        state, state_nxt;
    logic          pending;
    logic [1:0]    pend_mode;
    logic          cfg_acc;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          in_border, pix;

    vip_sync_edge u_vsync (
        .clk(clk), .rst_n(rst_n), .sig(in_frame_vsync),
        .sig_q(post_frame_vsync), .rise(vs_rise), .fall(vs_fall)
    );

    vip_sync_edge u_href (
        .clk(clk), .rst_n(rst_n), .sig(in_frame_href),
        .sig_q(post_frame_href), .rise(hs_rise), .fall(hs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (vs_rise) state_nxt = ST_FRAME;
            ST_FRAME: if (vs_fall) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A write landing on the vsync rise goes straight to the new frame.
    assign cfg_ready = ~pending;
    assign cfg_acc   = cfg_valid & cfg_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= 1'b0;
            pend_mode   <= MODE_BYPASS;
            active_mode <= MODE_BYPASS;
        end else if (vs_rise) begin
            pending <= 1'b0;
            if (cfg_acc)      active_mode <= cfg_mode;
            else if (pending) active_mode <= pend_mode;
        end else if (cfg_acc) begin
            pending   <= 1'b1;
            pend_mode <= cfg_mode;
        end
    end

    // col is the index of the pixel on the input this cycle; a line start
    // restarts it even if the previous line end was missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else begin
            if (hs_fall)
                col <= '0;
            else if (in_frame_href && in_frame_clken)
                col <= hs_rise ? CW'(1) : ((col == H_MAX) ? col : col + CW'(1));

            if (vs_rise)
                row <= '0;
            else if (hs_fall && row != V_MAX)
                row <= row + RW'(1);
        end
    end

    assign in_border = (col < H_LO) || (col >= H_HI) || (row < V_LO) || (row >= V_HI);
    assign pix = sel_bit(active_mode, in_raw_bit, in_ero_bit, in_dil_bit)
               & ~(is_morph(active_mode) & in_border);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 1'b0;
        end else begin
            post_frame_clken <= in_frame_clken;
            post_img_Bit     <= (state == ST_FRAME) & in_frame_href & pix;
        end
    end

`ifdef MORPH_STATS_EN
    logic        line_bad;
    logic [15:0] fcnt;
    logic        gerr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_bad <= 1'b0;
            fcnt     <= '0;
            gerr     <= 1'b0;
        end else begin
            if (vs_rise)
                line_bad <= 1'b0;
            else if (hs_fall && state == ST_FRAME && col != H_MAX)
                line_bad <= 1'b1;

            // Frames interrupted by reset never reach FRAME and are not counted.
            if (vs_fall && state == ST_FRAME) begin
                fcnt <= fcnt + 16'd1;
                if (row != V_MAX || line_bad) gerr <= 1'b1;
            end
        end
    end

    assign frame_cnt = fcnt;
    assign geom_err  = gerr;
`else
    assign frame_cnt = '0;
    assign geom_err  = 1'b0;
`endif

endmodule

// File: tb/tb_vip_morph_frame_ctrl.sv
// Directed bench for vip_morph_frame_ctrl (16x12 image, border 4); honours MORPH_STATS_EN.
module tb_vip_morph_frame_ctrl;

`ifdef MORPH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic        cfg_ready;
    logic        in_frame_vsync = 1'b0, in_frame_href = 1'b0, in_frame_clken = 1'b0;
    logic        in_raw_bit = 1'b0, in_ero_bit = 1'b0, in_dil_bit = 1'b0;
    logic        post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
    logic [1:0]  active_mode;
    logic [15:0] frame_cnt;
    logic        geom_err;

    int   n_pass = 0, n_total = 0;
    int   f_ones, f_serr, f_berr;
    logic prev_vs = 1'b0, prev_hs = 1'b0, prev_exp = 1'b0;

    vip_morph_frame_ctrl #(.IMG_HSIZE(16), .IMG_VSIZE(12), .BORDER(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
        .in_frame_vsync(in_frame_vsync), .in_frame_href(in_frame_href),
        .in_frame_clken(in_frame_clken),
        .in_raw_bit(in_raw_bit), .in_ero_bit(in_ero_bit), .in_dil_bit(in_dil_bit),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_img_Bit(post_img_Bit),
        .active_mode(active_mode), .frame_cnt(frame_cnt), .geom_err(geom_err)
    );

    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [1:0] m, input int row, input int col,
                                     input logic r, input logic e, input logic d);
        logic b;
        case (m)
            2'd1:    b = e;
            2'd2:    b = d;
            default: b = r;
        endcase
        if ((m == 2'd1 || m == 2'd2) && (col < 4 || col >= 12 || row < 4 || row >= 8)) b = 1'b0;
        return b;
    endfunction

    // One cycle: outputs must hold the previous inputs until the edge, then follow.
    task automatic drive(input logic vs, input logic hs, input logic eb);
        in_frame_vsync = vs;
        in_frame_href  = hs;
        in_frame_clken = hs;
        #1;
        if (rst_n && (post_frame_vsync !== prev_vs || post_frame_href !== prev_hs ||
                      post_frame_clken !== prev_hs)) f_serr++;
        if (post_img_Bit !== prev_exp) f_berr++;
        @(posedge clk); #1;
        if (rst_n && (post_frame_vsync !== vs || post_frame_href !== hs ||
                      post_frame_clken !== hs)) f_serr++;
        if (post_img_Bit !== eb) f_berr++;
        if (post_img_Bit === 1'b1) f_ones++;
        prev_vs  = rst_n ? vs : 1'b0;
        prev_hs  = rst_n ? hs : 1'b0;
        prev_exp = eb;
    endtask

    task automatic run_frame(input int nlines, input int short_line, input logic [1:0] mode,
                             input int wr_line, input logic [1:0] wr_mode,
                             input int wr2_line, input logic [1:0] wr2_mode,
                             input bit wr_at_rise, input int rst_line,
                             input logic r, input logic e, input logic d,
                             input int exp_ones, input string name);
        bit kill = 1'b0;
        int len;
        f_ones = 0; f_serr = 0; f_berr = 0;
        in_raw_bit = r; in_ero_bit = e; in_dil_bit = d;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        if (wr_at_rise) begin cfg_valid = 1'b1; cfg_mode = wr_mode; end
        drive(1'b1, 1'b0, 1'b0);
        cfg_valid = 1'b0;
        if (wr_at_rise) begin
            n_total++;
            if (active_mode !== wr_mode)
                $display("FAIL %s mode_at_rise: got %0d expected %0d", name, active_mode, wr_mode);
            else n_pass++;
            n_total++;
            if (cfg_ready !== 1'b1)
                $display("FAIL %s ready_after_rise: got %0b expected 1", name, cfg_ready);
            else n_pass++;
        end
        drive(1'b1, 1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            if (l == rst_line) begin
                rst_n = 1'b0; kill = 1'b1;
                prev_vs = 1'b0; prev_hs = 1'b0; prev_exp = 1'b0;
                repeat (3) drive(1'b1, 1'b0, 1'b0);
                rst_n = 1'b1;
            end
            if (l == wr_line) begin
                cfg_valid = 1'b1; cfg_mode = wr_mode;
                drive(1'b1, 1'b0, 1'b0);
                cfg_valid = 1'b0;
                n_total++;
                if (cfg_ready !== 1'b0 || active_mode !== mode)
                    $display("FAIL %s pending: ready %0b mode %0d, expected ready 0 mode %0d",
                             name, cfg_ready, active_mode, mode);
                else n_pass++;
            end
            if (l == wr2_line) begin
                cfg_valid = 1'b1; cfg_mode = wr2_mode;
                drive(1'b1, 1'b0, 1'b0);
                cfg_valid = 1'b0;
            end
            len = (l == short_line) ? 15 : 16;
            for (int c = 0; c < len; c++)
                drive(1'b1, 1'b1, kill ? 1'b0 : exp_bit(mode, l, c, r, e, d));
            drive(1'b1, 1'b0, 1'b0);
            drive(1'b1, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        n_total++;
        if (f_serr !== 0) $display("FAIL %s sync: %0d bad samples, expected 0", name, f_serr);
        else n_pass++;
        n_total++;
        if (f_berr !== 0) $display("FAIL %s pixel: %0d bad samples, expected 0", name, f_berr);
        else n_pass++;
        n_total++;
        if (f_ones !== exp_ones) $display("FAIL %s ones: got %0d expected %0d", name, f_ones, exp_ones);
        else n_pass++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (cfg_ready !== 1'b1 || active_mode !== 2'd0)
            $display("FAIL reset_cfg: ready %0b mode %0d, expected 1 0", cfg_ready, active_mode);
        else n_pass++;
        n_total++;
        if (frame_cnt !== 16'd0 || geom_err !== 1'b0)
            $display("FAIL reset_stats: cnt %0d err %0b, expected 0 0", frame_cnt, geom_err);
        else n_pass++;
        n_total++;
        if (post_img_Bit !== 1'b0 || post_frame_vsync !== 1'b0 || post_frame_href !== 1'b0)
            $display("FAIL reset_out: bit %0b vs %0b hs %0b, expected 0", post_img_Bit,
                     post_frame_vsync, post_frame_href);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        run_frame(12, -1, 2'd0, -1, 2'd0, -1, 2'd0, 1'b0, -1, 1'b1, 1'b0, 1'b0, 192, "bypass");
        n_total++;
        if (frame_cnt !== (STATS ? 16'd1 : 16'd0) || geom_err !== 1'b0)
            $display("FAIL bypass_stats: cnt %0d err %0b, expected %0d 0", frame_cnt, geom_err,
                     STATS ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_cfg_midframe();
        // Second write at line 5 lands while the first is pending and must be dropped.
        run_frame(12, -1, 2'd0, 3, 2'd1, 5, 2'd2, 1'b0, -1, 1'b1, 1'b0, 1'b0, 192, "cfg_mid");
        n_total++;
        if (active_mode !== 2'd0 || cfg_ready !== 1'b0)
            $display("FAIL cfg_mid_hold: mode %0d ready %0b, expected 0 0", active_mode, cfg_ready);
        else n_pass++;
        run_frame(12, -1, 2'd1, -1, 2'd0, -1, 2'd0, 1'b0, -1, 1'b0, 1'b1, 1'b0, 32, "erode");
        n_total++;
        if (active_mode !== 2'd1 || cfg_ready !== 1'b1)
            $display("FAIL erode_commit: mode %0d ready %0b, expected 1 1", active_mode, cfg_ready);
        else n_pass++;
    endtask

    task automatic test_cfg_at_rise();
        run_frame(12, -1, 2'd2, -1, 2'd2, -1, 2'd0, 1'b1, -1, 1'b0, 1'b0, 1'b1, 32, "dilate");
        n_total++;
        if (frame_cnt !== (STATS ? 16'd4 : 16'd0))
            $display("FAIL dilate_cnt: got %0d expected %0d", frame_cnt, STATS ? 4 : 0);
        else n_pass++;
        run_frame(12, -1, 2'd3, -1, 2'd3, -1, 2'd0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 192, "reserved");
    endtask

    task automatic test_geom_lines();
        run_frame(11, -1, 2'd3, -1, 2'd0, -1, 2'd0, 1'b0, -1, 1'b1, 1'b0, 1'b0, 176, "short_frame");
        n_total++;
        if (geom_err !== STATS) $display("FAIL geom_lines: got %0b expected %0b", geom_err, STATS);
        else n_pass++;
        run_frame(12, -1, 2'd3, -1, 2'd0, -1, 2'd0, 1'b0, -1, 1'b1, 1'b0, 1'b0, 192, "good_after");
        n_total++;
        if (geom_err !== STATS) $display("FAIL geom_sticky: got %0b expected %0b", geom_err, STATS);
        else n_pass++;
    endtask

    task automatic test_geom_pixels();
        rst_n = 1'b0;
        prev_vs = 1'b0; prev_hs = 1'b0; prev_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_total++;
        if (geom_err !== 1'b0 || frame_cnt !== 16'd0 || active_mode !== 2'd0)
            $display("FAIL geom_reset: err %0b cnt %0d mode %0d, expected 0 0 0", geom_err,
                     frame_cnt, active_mode);
        else n_pass++;
        run_frame(12, 2, 2'd0, -1, 2'd0, -1, 2'd0, 1'b0, -1, 1'b1, 1'b0, 1'b0, 191, "short_line");
        n_total++;
        if (geom_err !== STATS || frame_cnt !== (STATS ? 16'd1 : 16'd0))
            $display("FAIL geom_pixels: err %0b cnt %0d, expected %0b %0d", geom_err, frame_cnt,
                     STATS, STATS ? 1 : 0);
        else n_pass++;
    endtask

    task automatic test_reset_midframe();
        run_frame(12, -1, 2'd0, -1, 2'd0, -1, 2'd0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 96, "mid_reset");
        n_total++;
        if (frame_cnt !== 16'd0 || geom_err !== 1'b0 || active_mode !== 2'd0)
            $display("FAIL mid_reset_state: cnt %0d err %0b mode %0d, expected 0 0 0", frame_cnt,
                     geom_err, active_mode);
        else n_pass++;
        run_frame(12, -1, 2'd0, -1, 2'd0, -1, 2'd0, 1'b0, -1, 1'b1, 1'b0, 1'b0, 192, "recover");
        n_total++;
        if (frame_cnt !== (STATS ? 16'd1 : 16'd0) || geom_err !== 1'b0)
            $display("FAIL recover_stats: cnt %0d err %0b, expected %0d 0", frame_cnt, geom_err,
                     STATS ? 1 : 0);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_cfg_midframe();
        test_cfg_at_rise();
        test_geom_lines();
        test_geom_pixels();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
